egg_count_ctrl: RTL

//   Egg-tray state controller that sits directly upstream of the dot-matrix egg display.

---
 rtl/egg_count_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/egg_count_ctrl.sv
// rtl/egg_count_ctrl.sv - debounced take/add egg counter with empty-tray auto-refill
module egg_count_ctrl #(
    parameter int MAX_EGGS   = 4,
    parameter int DEB_CYC    = 20,
    parameter int REFILL_CYC = 3000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_take,
    input  logic       key_add,
    output logic [2:0] num,
    output logic       empty,
    output logic       full,
    output logic       refill
);

    localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int TW = (REFILL_CYC > 1) ? $clog2(REFILL_CYC) : 1;
    localparam logic [2:0]    MAX_NUM  = 3'(MAX_EGGS);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(REFILL_CYC - 1);

    typedef enum logic [1:0] {
        NORMAL     = 2'd0,
        EMPTY_WAIT = 2'd1,
        REFILL     = 2'd2
    } state_t;

    logic [1:0] keys;
    logic [1:0] press;

    assign keys = {key_add, key_take};

    // Per key: 2-FF synchronizer, stable-window debounce, registered rising-edge pulse.
    for (genvar g = 0; g < 2; g++) begin : g_key
        logic          s1, s2, deb, deb_d, pulse;
        logic [DW-1:0] cnt;

        always_ff @(posedge clk) begin
            if (!rst) begin
                s1    <= 1'b0;
                s2    <= 1'b0;
                deb   <= 1'b0;
                deb_d <= 1'b0;
                pulse <= 1'b0;
                cnt   <= '0;
            end else begin
                s1    <= keys[g];
                s2    <= s1;
                deb_d <= deb;
                pulse <= deb & ~deb_d;
                if (s2 == deb) begin
                    cnt <= '0;
                end else if (cnt == DEB_LAST) begin
                    deb <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign press[g] = pulse;
    end

    logic take, add;
    assign take = press[0] & ~press[1];
    assign add  = press[1] & ~press[0];

    state_t        state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [2:0]    num_next;
    logic          refill_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= NORMAL;
            timer  <= '0;
            num    <= MAX_NUM;
            empty  <= 1'b0;
            full   <= 1'b1;
            refill <= 1'b0;
        end else begin
            state  <= state_next;
            timer  <= timer_next;
            num    <= num_next;
            empty  <= (num_next == 3'd0);
            full   <= (num_next == MAX_NUM);
            refill <= refill_next;
        end
    end

    // An add on the timeout cycle takes priority over the refill.
    always_comb begin
        state_next = state;
        case (state)
            NORMAL:     if (take && num == 3'd1) state_next = EMPTY_WAIT;
            EMPTY_WAIT: begin
                if (add)                     state_next = NORMAL;
                else if (timer == TMR_LAST)  state_next = REFILL;
            end
            REFILL:     state_next = NORMAL;
            default:    state_next = NORMAL;
        endcase
    end

    always_comb begin
        num_next    = num;
        refill_next = 1'b0;
        timer_next  = '0;
        case (state)
            NORMAL, EMPTY_WAIT: begin
                if (take && num != 3'd0)         num_next = num - 3'd1;
                else if (add && num != MAX_NUM)  num_next = num + 3'd1;
                if (state == EMPTY_WAIT && state_next == EMPTY_WAIT)
                    timer_next = timer + 1'b1;
            end
            REFILL: begin
                num_next    = MAX_NUM;
                refill_next = 1'b1;
            end
            default: num_next = MAX_NUM;
        endcase
    end

endmodule
